// File: rtl/my_not_array_pkg.sv
// Shared constants for the my_not_array inverter block: mode encoding and
// default channel / divider widths.
package my_not_array_pkg;

    typedef enum logic {
        MODE_INVERT = 1'b0,
        MODE_TOGGLE = 1'b1
    } mode_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIV_W = 8;

endpackage : my_not_array_pkg

// File: rtl/my_not_divider.sv
// Programmable wrap divider: counts 0..div_reg and flags a wrap every
// div_reg+1 cycles; tick is the registered copy of that wrap.
module my_not_divider #(
    parameter int DIV_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    output logic             wrap,
    output logic             tick
);

    logic [DIV_W-1:0] div_reg_q, div_reg_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else can leave a value unassigned and infer a latch.
    always_comb begin
        div_reg_d = div_reg_q;
        cnt_d     = cnt_q;
        wrap      = 1'b0;
        if (div_load) begin
            // A load restarts the period from 0 and suppresses the wrap, even
            // when the new reload value is below the running count.
            div_reg_d = div_value;
            cnt_d     = '0;
        end else if (cnt_q == div_reg_q) begin
            cnt_d = '0;
            wrap  = 1'b1;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
        tick_d = wrap;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_reg_q <= '0;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
        end else begin
            div_reg_q <= div_reg_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule : my_not_divider

// File: rtl/my_not_array.sv
// Array of independent registered inverters: each channel either inverts its
// data input or toggles on every divider wrap, gated by its own enable.
module my_not_array
    import my_not_array_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIV_W = DEFAULT_DIV_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] enable,
    input  logic             mode,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    output logic [WIDTH-1:0] out,
    output logic             tick
);

    logic             wrap;
    logic [WIDTH-1:0] out_q, out_d;

    // The divider free-runs in both modes so tick stays meaningful in invert mode.
    my_not_divider #(
        .DIV_W (DIV_W)
    ) u_divider (
        .clock     (clock),
        .reset     (reset),
        .div_load  (div_load),
        .div_value (div_value),
        .wrap      (wrap),
        .tick      (tick)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic next_bit;

        always_comb begin
            next_bit = out_q[i];
            if (enable[i]) begin
                if (mode == MODE_TOGGLE) begin
                    next_bit = out_q[i] ^ wrap;
                end else begin
                    next_bit = ~in_data[i];
                end
            end
        end

        assign out_d[i] = next_bit;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule : my_not_array

// File: tb/tb_my_not_array.sv
// Self-checking bench for my_not_array: a cycle model pushes expected out/tick
// into a scoreboard queue on each drive; the sample after the edge pops it.
module tb_my_not_array;
    import my_not_array_pkg::*;

    localparam int WIDTH = DEFAULT_WIDTH;
    localparam int DIV_W = DEFAULT_DIV_W;

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] enable;
    logic             mode;
    logic             div_load;
    logic [DIV_W-1:0] div_value;
    logic [WIDTH-1:0] out;
    logic             tick;

    my_not_array #(
        .WIDTH (WIDTH),
        .DIV_W (DIV_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .enable    (enable),
        .mode      (mode),
        .div_load  (div_load),
        .div_value (div_value),
        .out       (out),
        .tick      (tick)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [WIDTH-1:0] out;
        logic             tick;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference state, written straight from the behavioural description.
    logic [DIV_W-1:0] m_div = '0;
    logic [DIV_W-1:0] m_cnt = '0;
    logic [WIDTH-1:0] m_out = '0;
    logic             m_tick = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_step();
        logic w;
        if (reset) begin
            m_div = '0; m_cnt = '0; m_out = '0; m_tick = 1'b0;
        end else begin
            w = (m_cnt == m_div) && !div_load;
            for (int i = 0; i < WIDTH; i++) begin
                if (enable[i]) m_out[i] = mode ? (w ? ~m_out[i] : m_out[i]) : ~in_data[i];
            end
            m_tick = w;
            if (div_load) begin
                m_div = div_value;
                m_cnt = '0;
            end else if (m_cnt == m_div) begin
                m_cnt = '0;
            end else begin
                m_cnt = m_cnt + 1'b1;
            end
        end
    endtask

    // One clock edge: predict, push, clock, sample 1 time unit later, pop and compare.
    task automatic cycle();
        exp_t e;
        model_step();
        e.out  = m_out;
        e.tick = m_tick;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        check("sb_out", 32'(out), 32'(e.out));
        check("sb_tick", 32'(tick), 32'(e.tick));
    endtask

    // Runs n idle edges and reports tick count, first tick position, first gap.
    task automatic run_ticks(input int n, output int count, output int first_at, output int gap);
        int last;
        last = -1; count = 0; first_at = -1; gap = -1;
        for (int k = 1; k <= n; k++) begin
            cycle();
            if (tick === 1'b1) begin
                if (first_at < 0) first_at = k;
                else if (gap < 0) gap = k - last;
                count++;
                last = k;
            end
        end
    endtask

    task automatic load(input logic [DIV_W-1:0] v);
        div_load  = 1'b1;
        div_value = v;
        cycle();
        div_load  = 1'b0;
    endtask

    initial begin
        int cnt, first, gap;

        reset = 1'b1; mode = 1'b0; div_load = 1'b0; div_value = '0;
        in_data = '0; enable = '0;

        // Reset for two cycles, idle release: tick every cycle with div_reg = 0.
        cycle();
        cycle();
        reset = 1'b0;
        run_ticks(4, cnt, first, gap);
        check("idle_out", 32'(out), 32'h00);
        check("idle_tick_count", 32'(cnt), 32'd4);
        check("idle_first_tick", 32'(first), 32'd1);

        // Invert mode with full and partial enable.
        enable = 8'hFF; in_data = 8'hA5;
        cycle();
        check("inv_a5", 32'(out), 32'h5A);
        enable = 8'hF0; in_data = 8'h0F;
        cycle();
        check("inv_partial", 32'(out), 32'hFA);

        // Toggle divide by 4 on channel 0 only.
        mode = 1'b1; enable = 8'h01; in_data = 8'h00;
        load(8'd3);
        check("load_no_tick", 32'(tick), 32'd0);
        run_ticks(16, cnt, first, gap);
        check("tog_tick_count", 32'(cnt), 32'd4);
        check("tog_first_tick", 32'(first), 32'd4);
        check("tog_tick_gap", 32'(gap), 32'd4);
        check("tog_hold_upper", 32'(out[7:1]), 32'h7D);
        run_ticks(4, cnt, first, gap);
        check("tog_bit0_flipped", 32'(out), 32'hFB);

        // Mode 0 -> 1 switch two edges into a 6-cycle period keeps the count.
        mode = 1'b0; enable = 8'h00;
        load(8'd5);
        cycle();
        cycle();
        mode = 1'b1; enable = 8'hFF;
        run_ticks(10, cnt, first, gap);
        check("switch_first_tick", 32'(first), 32'd4);
        check("switch_gap", 32'(gap), 32'd6);
        check("switch_count", 32'(cnt), 32'd2);

        // Reload below the running count: div_reg 9, cnt 7, then load 2.
        mode = 1'b0; enable = 8'h00;
        load(8'd9);
        for (int k = 0; k < 7; k++) cycle();
        load(8'd2);
        check("reload_no_tick", 32'(tick), 32'd0);
        run_ticks(3, cnt, first, gap);
        check("reload_first_tick", 32'(first), 32'd3);

        // Largest reload value: 256-cycle period, no overflow tick.
        load(8'd255);
        run_ticks(520, cnt, first, gap);
        check("max_first_tick", 32'(first), 32'd256);
        check("max_gap", 32'(gap), 32'd256);
        check("max_count", 32'(cnt), 32'd2);

        // Randomised mix of modes, enables, data and occasional small loads.
        for (int k = 0; k < 40; k++) begin
            in_data   = WIDTH'($urandom);
            enable    = WIDTH'($urandom);
            mode      = 1'($urandom);
            div_load  = ($urandom_range(0, 7) == 0);
            div_value = DIV_W'($urandom_range(0, 4));
            cycle();
        end
        div_load = 1'b0;

        // Reset wins over a simultaneous load; divider then runs with div_reg 0.
        mode = 1'b1; enable = 8'hFF;
        reset = 1'b1; div_load = 1'b1; div_value = 8'd5;
        cycle();
        check("rst_load_out", 32'(out), 32'h00);
        check("rst_load_tick", 32'(tick), 32'd0);
        reset = 1'b0; div_load = 1'b0; mode = 1'b0; enable = 8'h00;
        run_ticks(4, cnt, first, gap);
        check("rst_load_divreg0", 32'(cnt), 32'd4);

        // Reset mid-period aborts it.
        load(8'd4);
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        run_ticks(5, cnt, first, gap);
        check("midrst_count", 32'(cnt), 32'd5);
        check("midrst_first", 32'(first), 32'd1);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_my_not_array

// File: doc/my_not_array.md
MY_NOT_ARRAY -- requirements
Module: my_not_array

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of independent inverter channels (1..32).
REQ-002 The block SHALL have parameter DIV_W, default 8: width of the toggle divider counter and reload value.
REQ-003 The block SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port in_data, input, WIDTH: per-channel data inputs for invert mode.
REQ-006 The block SHALL have port enable, input, WIDTH: per-channel update enable; a disabled channel holds its output.
REQ-007 The block SHALL have port mode, input, 1: 0 = registered invert, 1 = toggle (divided clock) mode.
REQ-008 The block SHALL have port div_load, input, 1: single-cycle strobe that loads div_value.
REQ-009 The block SHALL have port div_value, input, DIV_W: divider reload value N; the toggle period is N+1 cycles.
REQ-010 The block SHALL have port out, output, WIDTH: registered channel outputs.
REQ-011 The block SHALL have port tick, output, 1: registered pulse marking a divider wrap.

Function
REQ-012 Internal state SHALL consist of div_reg (DIV_W), cnt (DIV_W), out (WIDTH) and tick (1).
REQ-013 wrap SHALL be defined as (cnt == div_reg) and not div_load.
REQ-014 On each edge where div_load is low, cnt SHALL become 0 if cnt == div_reg; otherwise cnt SHALL become cnt+1.
REQ-015 On an edge where div_load is high, div_reg SHALL become div_value and cnt SHALL become 0, with no wrap that cycle.
REQ-016 tick SHALL be registered from wrap, so tick is high for exactly the one cycle after each wrap edge.
REQ-017 With div_reg = 0 and no load, tick SHALL be high every cycle.
REQ-018 In mode 0, out[i] SHALL become ~in_data[i] on each edge where enable[i] = 1, giving 1-cycle latency; wrap SHALL NOT affect out.
REQ-019 In mode 1, out[i] SHALL become ~out[i] on each wrap edge where enable[i] = 1, and SHALL hold otherwise; in_data SHALL be ignored.
REQ-020 Where enable[i] = 0, out[i] SHALL hold in both modes.
REQ-021 A mode change SHALL take effect at the next edge; out, cnt and div_reg SHALL NOT be cleared by the change.
REQ-022 The divider SHALL run continuously in both modes, so tick is valid in mode 0.
REQ-023 cnt SHALL NOT exceed div_reg.
REQ-024 If div_value is loaded below the current cnt, REQ-015 SHALL apply and cnt SHALL restart at 0, with no wrap-around through 2^DIV_W.
REQ-025 Channels SHALL be fully independent; per-bit enable changes SHALL cause no glitch or coupling between channels.

Reset
REQ-026 While reset is high at an edge, out SHALL be all 0s, tick 0, cnt 0 and div_reg 0.
REQ-027 reset SHALL take priority over div_load, mode and enable when they are simultaneous.
REQ-028 Reset asserted mid-period SHALL abort the period, and the first wrap after release SHALL occur per div_reg = 0.
REQ-029 The block SHALL contain no asynchronous reset path and no initial-value dependence.

Structure
REQ-030 A shared package SHALL hold the mode encoding constants MODE_INVERT = 0 and MODE_TOGGLE = 1, and the default WIDTH and DIV_W values.
REQ-031 The divider (cnt, div_reg, wrap, tick) SHALL be one sub-module, my_not_divider, parametrised by DIV_W.
REQ-032 The channel array SHALL be a generate loop in my_not_array.

Verification
REQ-033 Reset then idle: reset high 2 cycles, then low with mode = 0 and enable = 0 -> out = 0x00, and tick high every cycle from the first edge after release.
REQ-034 Invert mode: WIDTH = 8, enable = 0xFF, in_data = 0xA5 -> out = 0x5A one cycle later; then in_data = 0x0F with enable = 0xF0 -> out = 0xFA.
REQ-035 Toggle divide: load div_value = 3, mode = 1, enable = 0x01 -> tick pulses every 4 cycles, out[0] toggles every 4 cycles (period 8), and out[7:1] holds.
REQ-036 Reload mid-count: div_reg = 9 and cnt = 7, then load 2 -> no tick in the load cycle, and the next tick follows 3 edges later.
REQ-037 Simultaneous events: reset and div_load (value 5) on the same edge -> div_reg = 0 and out = 0; a mode 0->1 switch mid-period keeps cnt continuous.
REQ-038 Boundary: div_value = 2^DIV_W-1 (255) -> tick period 256 cycles, with no counter overflow or extra tick.
